// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ps2_rx_fifo
// Purpose  : PS/2 device-to-host receiver: clock glitch filter, 11-bit frame
//            checks, stall timeout and a first-word-fall-through scancode FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_rx_fifo #(
  parameter int FILTER_LEN   = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int TIMEOUT      = 2048,
  parameter int CHECK_PARITY = 1
) (
  input  logic                        clk,
  input  logic                        RESET,
  input  logic                        clk_en,
  input  logic                        PS2_CLK,
  input  logic                        PS2_DATA,
  input  logic                        RD,
  output logic [7:0]                  DATA,
  output logic                        VALID,
  output logic [$clog2(FIFO_DEPTH):0] COUNT,
  output logic                        PARITY_ERR,
  output logic                        FRAME_ERR,
  output logic                        OVERFLOW
);

  localparam int c_aw   = $clog2(FIFO_DEPTH);
  localparam int c_cw   = c_aw + 1;
  localparam int c_to_w = $clog2(TIMEOUT + 1);
  localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT - 1);
  localparam logic [c_cw-1:0]   c_full    = c_cw'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [FILTER_LEN-1:0]   filt_q, filt_d;
  logic                    armed_q, armed_d;
  logic                    pend_q, pend_d;
  logic [3:0]              bitcnt_q, bitcnt_d;
  logic [9:0]              sr_q, sr_d;
  logic [c_to_w-1:0]       to_q, to_d;
  logic                    perr_q, perr_d;
  logic                    ferr_q, ferr_d;
  logic                    ovf_q, ovf_d;
  logic [c_aw-1:0]         wr_q, wr_d;
  logic [c_aw-1:0]         rd_q, rd_d;
  logic [c_cw-1:0]         cnt_q, cnt_d;
  logic [7:0]              mem_q [FIFO_DEPTH];
  logic [7:0]              mem_d [FIFO_DEPTH];

  logic [FILTER_LEN-1:0]   w_shift;
  logic                    w_fe;
  logic                    w_sample;
  logic                    w_timeout;
  logic                    w_push_req;
  logic                    w_full;
  logic                    w_pop;
  logic                    w_push;

  // Filter, sampling, timeout and frame FSM.
  always_comb begin
    state_d    = state_q;
    filt_d     = filt_q;
    armed_d    = armed_q;
    pend_d     = pend_q;
    bitcnt_d   = bitcnt_q;
    sr_d       = sr_q;
    to_d       = to_q;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;
    w_fe       = 1'b0;
    w_push_req = 1'b0;
    w_shift    = {filt_q[FILTER_LEN-2:0], PS2_CLK};

    // An edge needs a full high window to re-arm, so each low phase yields one FE.
    if (clk_en) begin
      filt_d = w_shift;
      if (&w_shift) begin
        armed_d = 1'b1;
      end else if (armed_q && (w_shift == '0)) begin
        w_fe    = 1'b1;
        armed_d = 1'b0;
      end
      pend_d = w_fe;
    end
    w_sample  = clk_en && pend_q;
    w_timeout = clk_en && (to_q == c_to_last) && !w_fe;

    if ((state_q == IDLE) || w_fe) begin
      to_d = '0;
    end else if (clk_en) begin
      to_d = to_q + c_to_w'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (w_sample) begin
          if (!PS2_DATA) begin
            state_d  = SHIFT;
            bitcnt_d = 4'd0;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (w_timeout) begin
          state_d = IDLE;
          ferr_d  = 1'b1;
        end else if (w_sample) begin
          sr_d = {PS2_DATA, sr_q[9:1]};
          if (bitcnt_q == 4'd9) begin
            state_d = CHECK;
          end else begin
            bitcnt_d = bitcnt_q + 4'd1;
          end
        end
      end
      CHECK: begin
        // sr_q = {stop, parity, data[7:0]}; stop errors mask parity errors.
        if (clk_en) begin
          state_d = IDLE;
          if (!sr_q[9]) begin
            ferr_d = 1'b1;
          end else if ((CHECK_PARITY != 0) && !(^sr_q[8:0])) begin
            perr_d = 1'b1;
          end else begin
            w_push_req = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Scancode FIFO; a pop on a full push cycle frees the slot for the push.
  always_comb begin
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    ovf_d  = ovf_q;
    w_full = (cnt_q == c_full);
    w_pop  = RD && (cnt_q != '0);
    w_push = w_push_req && (!w_full || w_pop);
    if (w_push_req && w_full && !w_pop) begin
      ovf_d = 1'b1;
    end
    if (w_push) begin
      mem_d[wr_q] = sr_q[7:0];
      wr_d        = wr_q + c_aw'(1);
    end
    if (w_pop) begin
      rd_d = rd_q + c_aw'(1);
    end
    cnt_d = cnt_q + c_cw'(w_push) - c_cw'(w_pop);
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q  <= IDLE;
      filt_q   <= '1;
      armed_q  <= 1'b0;
      pend_q   <= 1'b0;
      bitcnt_q <= '0;
      sr_q     <= '0;
      to_q     <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      mem_q    <= '{default: 8'h00};
    end else begin
      state_q  <= state_d;
      filt_q   <= filt_d;
      armed_q  <= armed_d;
      pend_q   <= pend_d;
      bitcnt_q <= bitcnt_d;
      sr_q     <= sr_d;
      to_q     <= to_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      ovf_q    <= ovf_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

  assign VALID      = (cnt_q != '0);
  assign DATA       = VALID ? mem_q[rd_q] : 8'h00;
  assign COUNT      = cnt_q;
  assign PARITY_ERR = perr_q;
  assign FRAME_ERR  = ferr_q;
  assign OVERFLOW   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_rx_fifo
// Purpose  : Directed bench; frames are bit-banged with clk_en every other clk.
//            Two instances differ only in CHECK_PARITY.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_rx_fifo;

  localparam int FILTER_LEN = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int TIMEOUT    = 64;
  localparam int HALF       = 12;
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;

  logic          clk      = 1'b0;
  logic          RESET    = 1'b1;
  logic          clk_en   = 1'b0;
  logic          PS2_CLK  = 1'b1;
  logic          PS2_DATA = 1'b1;
  logic          RD       = 1'b0;
  logic [7:0]    data, data_np;
  logic          valid, valid_np;
  logic [CW-1:0] count, count_np;
  logic          perr, ferr, ovf, perr_np, ferr_np, ovf_np;

  ps2_rx_fifo #(.FILTER_LEN(FILTER_LEN), .FIFO_DEPTH(FIFO_DEPTH),
                .TIMEOUT(TIMEOUT), .CHECK_PARITY(1)) dut (
    .clk(clk), .RESET(RESET), .clk_en(clk_en), .PS2_CLK(PS2_CLK),
    .PS2_DATA(PS2_DATA), .RD(RD), .DATA(data), .VALID(valid), .COUNT(count),
    .PARITY_ERR(perr), .FRAME_ERR(ferr), .OVERFLOW(ovf)
  );

  ps2_rx_fifo #(.FILTER_LEN(FILTER_LEN), .FIFO_DEPTH(FIFO_DEPTH),
                .TIMEOUT(TIMEOUT), .CHECK_PARITY(0)) dut_np (
    .clk(clk), .RESET(RESET), .clk_en(clk_en), .PS2_CLK(PS2_CLK),
    .PS2_DATA(PS2_DATA), .RD(RD), .DATA(data_np), .VALID(valid_np), .COUNT(count_np),
    .PARITY_ERR(perr_np), .FRAME_ERR(ferr_np), .OVERFLOW(ovf_np)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1 clk_en = ~clk_en;
    end
  end

  // Pulse counters; a pulse lasting two clks counts as wide.
  int   perr_cnt = 0, ferr_cnt = 0, perr_np_cnt = 0, ferr_np_cnt = 0, wide_cnt = 0;
  logic perr_p = 1'b0, ferr_p = 1'b0, perr_np_p = 1'b0, ferr_np_p = 1'b0;
  always @(negedge clk) begin
    if (perr)    perr_cnt++;
    if (ferr)    ferr_cnt++;
    if (perr_np) perr_np_cnt++;
    if (ferr_np) ferr_np_cnt++;
    if ((perr && perr_p) || (ferr && ferr_p) || (perr_np && perr_np_p) || (ferr_np && ferr_np_p))
      wide_cnt++;
    perr_p    = perr;
    ferr_p    = ferr;
    perr_np_p = perr_np;
    ferr_np_p = ferr_np;
  end

  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!clk_en) @(posedge clk);
    end
    #2;
  endtask

  // One bit: data set in the high phase, then a HALF-tick low phase.
  // pop_at_check raises RD exactly on the CHECK tick edge of a stop bit.
  task automatic send_bit(input logic b, input bit pop_at_check);
    PS2_DATA = b;
    ticks(HALF);
    PS2_CLK = 1'b0;
    if (pop_at_check) begin
      ticks(9);
      @(posedge clk); #2;
      RD = 1'b1;
      @(posedge clk); #2;
      RD = 1'b0;
      ticks(HALF - 10);
    end else begin
      ticks(HALF);
    end
    PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit flip, input logic stop,
                            input bit pop_at_check);
    logic [10:0] bits;
    bits = {stop, (~(^d)) ^ flip, d, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(bits[i], pop_at_check && (i == 10));
    PS2_DATA = 1'b1;
    ticks(HALF);
  endtask

  task automatic pop();
    RD = 1'b1;
    @(posedge clk); #2;
    RD = 1'b0;
  endtask

  typedef struct {
    logic [7:0] d;
    bit         flip;
    logic       stop;
    bit         exp_push;
    bit         exp_perr;
    bit         exp_ferr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int         p0, f0, pn0, fn0, n;
    bit         found;
    logic [7:0] pb, exp_b;

    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{8'h6B, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #2 RESET = 1'b0;
    chk("rst_valid", valid, 0);
    chk("rst_count", count, 0);
    chk("rst_data", data, 8'h00);
    chk("rst_perr", perr, 0);
    chk("rst_ferr", ferr, 0);
    chk("rst_ovf", ovf, 0);
    ticks(HALF);

    for (int i = 0; i < 8; i++) begin
      p0 = perr_cnt; f0 = ferr_cnt; pn0 = perr_np_cnt; fn0 = ferr_np_cnt;
      send_frame(vecs[i].d, vecs[i].flip, vecs[i].stop, 1'b0);
      chk($sformatf("v%0d_count", i), count, vecs[i].exp_push);
      if (vecs[i].exp_push) chk($sformatf("v%0d_data", i), data, vecs[i].d);
      chk($sformatf("v%0d_np_count", i), count_np, vecs[i].stop);
      if (vecs[i].stop) chk($sformatf("v%0d_np_data", i), data_np, vecs[i].d);
      chk($sformatf("v%0d_perr", i), perr_cnt - p0, vecs[i].exp_perr);
      chk($sformatf("v%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
      chk($sformatf("v%0d_np_perr", i), perr_np_cnt - pn0, 0);
      chk($sformatf("v%0d_np_ferr", i), ferr_np_cnt - fn0, vecs[i].exp_ferr);
      if (valid || valid_np) pop();
      chk($sformatf("v%0d_count_after_pop", i), count, 0);
      chk($sformatf("v%0d_np_count_after_pop", i), count_np, 0);
    end

    // Start bit sampled as 1.
    f0 = ferr_cnt;
    send_bit(1'b1, 1'b0);
    ticks(HALF);
    chk("bad_start_ferr", ferr_cnt - f0, 1);
    chk("bad_start_count", count, 0);

    // Low glitch one tick shorter than the filter.
    f0 = ferr_cnt; p0 = perr_cnt;
    PS2_CLK = 1'b0;
    ticks(FILTER_LEN - 1);
    PS2_CLK = 1'b1;
    ticks(TIMEOUT + HALF);
    chk("glitch_ferr", ferr_cnt - f0, 0);
    chk("glitch_perr", perr_cnt - p0, 0);
    chk("glitch_count", count, 0);

    // Stalled frame: start + 4 data bits, then clock held high.
    f0 = ferr_cnt;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    n = HALF - FILTER_LEN;
    found = 1'b0;
    while (!found && (n < 4 * TIMEOUT)) begin
      ticks(1);
      n++;
      if (ferr) found = 1'b1;
    end
    chk("timeout_seen", found, 1);
    chk("timeout_ticks", n, TIMEOUT);
    PS2_DATA = 1'b1;
    ticks(HALF);
    chk("timeout_ferr_cnt", ferr_cnt - f0, 1);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    chk("after_timeout_valid", valid, 1);
    chk("after_timeout_data", data, 8'hF0);
    chk("after_timeout_count", count, 1);
    chk("after_timeout_ferr_cnt", ferr_cnt - f0, 1);
    pop();

    // Fill past full, then push with a simultaneous pop.
    for (int k = 1; k <= 9; k++) send_frame(8'(k), 1'b0, 1'b1, 1'b0);
    chk("full_count", count, FIFO_DEPTH);
    chk("full_ovf", ovf, 1);
    chk("full_head", data, 8'h01);
    chk("full_np_ovf", ovf_np, 1);
    send_frame(8'h0A, 1'b0, 1'b1, 1'b1);
    chk("full_pushpop_count", count, FIFO_DEPTH);
    chk("full_pushpop_ovf", ovf, 1);
    for (int j = 0; j < FIFO_DEPTH; j++) begin
      exp_b = (j < FIFO_DEPTH - 1) ? 8'(j + 2) : 8'h0A;
      chk($sformatf("drain%0d_valid", j), valid, 1);
      chk($sformatf("drain%0d_data", j), data, exp_b);
      pop();
    end
    chk("drained_valid", valid, 0);
    chk("drained_count", count, 0);
    pop();
    chk("empty_pop_count", count, 0);
    chk("ovf_sticky", ovf, 1);

    // Reset mid-frame with two bytes queued.
    send_frame(8'h11, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0);
    chk("pre_reset_count", count, 2);
    f0 = ferr_cnt; p0 = perr_cnt;
    pb = 8'h33;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(pb[i], 1'b0);
    PS2_DATA = pb[5];
    ticks(HALF);
    PS2_CLK = 1'b0;
    ticks(4);
    RESET = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    RESET = 1'b0;
    ticks(HALF - 4);
    PS2_CLK  = 1'b1;
    PS2_DATA = 1'b1;
    ticks(TIMEOUT + HALF);
    chk("post_reset_count", count, 0);
    chk("post_reset_valid", valid, 0);
    chk("post_reset_ovf", ovf, 0);
    chk("post_reset_ferr", ferr_cnt - f0, 0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    chk("post_reset_5a_valid", valid, 1);
    chk("post_reset_5a_data", data, 8'h5A);
    chk("post_reset_5a_count", count, 1);
    chk("post_reset_5a_errs", (ferr_cnt - f0) + (perr_cnt - p0), 0);

    chk("pulse_width", wide_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
